// File: rtl/board_pkg.sv
// Shared board geometry, reader state encoding and cell addressing helper.
// Used by the game controller, the board reader and the renderer.
package board_pkg;

   localparam int unsigned CELLS   = 16;
   localparam int unsigned CELL_W  = 20;
   localparam int unsigned EXP_W   = 5;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned SCORE_W = 21;
   localparam int unsigned CNT_W   = 5;

   typedef enum logic [1:0] {
      StIdle,
      StEmit,
      StDone
   } state_e;

   // Bit offset of a cell inside the flattened board vector.
   function automatic int unsigned cell_offset(input int unsigned idx,
                                               input int unsigned w = CELL_W);
      return idx * w;
   endfunction

endpackage

// File: rtl/tile_log2.sv
// Combinational tile decode: floor(log2) of a cell value, plus a flag for
// values that are not a legal tile (non-zero and not a power of two >= 2).
module tile_log2 #(
   parameter int unsigned CELL_W = board_pkg::CELL_W,
   parameter int unsigned EXP_W  = board_pkg::EXP_W
) (
   input  logic [CELL_W-1:0] value,
   output logic [EXP_W-1:0]  exp_val,
   output logic              bad
);

   // Highest set bit wins; later iterations override earlier ones.
   always_comb begin
      exp_val = '0;
      for (int unsigned i = 0; i < CELL_W; i++) begin
         if (value[i]) begin
            exp_val = EXP_W'(i);
         end
      end
   end

   // A value of 1 would be the 2^0 tile, which the game never produces.
   always_comb begin
      bad = (value == CELL_W'(1)) || ((value & (value - 1'b1)) != '0);
   end

endmodule

// File: rtl/board_reader.sv
// Snapshots the game board on start and streams its cells as (index, exponent)
// records over valid/ready, then reports highest tile and empty-cell count.
module board_reader #(
   parameter int unsigned CELLS  = board_pkg::CELLS,
   parameter int unsigned CELL_W = board_pkg::CELL_W,
   parameter int unsigned EXP_W  = board_pkg::EXP_W
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [CELLS*CELL_W-1:0]     board,
   input  logic [board_pkg::SCORE_W-1:0] score,
   input  logic                        start,
   output logic                        busy,
   output logic                        tile_valid,
   input  logic                        tile_ready,
   output logic [board_pkg::IDX_W-1:0] tile_idx,
   output logic [EXP_W-1:0]            tile_exp,
   output logic                        tile_bad,
   output logic [board_pkg::SCORE_W-1:0] score_snap,
   output logic                        done,
   output logic [EXP_W-1:0]            max_exp,
   output logic [board_pkg::CNT_W-1:0] empty_cnt
);

   import board_pkg::*;

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(CELLS - 1);

   state_e                    state_q;
   logic [CELLS*CELL_W-1:0]   board_q;
   logic [SCORE_W-1:0]        score_q;
   logic [IDX_W-1:0]          idx_q;
   logic [EXP_W-1:0]          max_acc_q;
   logic [CNT_W-1:0]          empty_acc_q;
   logic                      busy_q;
   logic                      valid_q;
   logic                      done_q;
   logic [EXP_W-1:0]          max_exp_q;
   logic [CNT_W-1:0]          empty_cnt_q;

   logic [CELL_W-1:0]         cells [CELLS];
   logic [CELL_W-1:0]         cell_sel;
   logic [EXP_W-1:0]          cur_exp;
   logic                      cur_bad;
   logic [EXP_W-1:0]          max_fold;
   logic [CNT_W-1:0]          empty_fold;

   for (genvar i = 0; i < CELLS; i++) begin : g_cells
      assign cells[i] = board_q[cell_offset(i, CELL_W) +: CELL_W];
   end

   assign cell_sel = cells[idx_q];

   tile_log2 #(
      .CELL_W (CELL_W),
      .EXP_W  (EXP_W)
   ) u_tile_log2 (
      .value   (cell_sel),
      .exp_val (cur_exp),
      .bad     (cur_bad)
   );

   // Accumulator values including the record currently on the bus.
   always_comb begin
      max_fold   = (cur_exp > max_acc_q) ? cur_exp : max_acc_q;
      empty_fold = empty_acc_q + CNT_W'(cell_sel == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         board_q     <= '0;
         score_q     <= '0;
         idx_q       <= '0;
         max_acc_q   <= '0;
         empty_acc_q <= '0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         max_exp_q   <= '0;
         empty_cnt_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q     <= StEmit;
                  board_q     <= board;
                  score_q     <= score;
                  idx_q       <= '0;
                  max_acc_q   <= '0;
                  empty_acc_q <= '0;
                  busy_q      <= 1'b1;
                  valid_q     <= 1'b1;
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b0;
               end
            end
            StEmit: begin
               if (tile_ready) begin
                  max_acc_q   <= max_fold;
                  empty_acc_q <= empty_fold;
                  if (idx_q == LastIdx) begin
                     state_q     <= StDone;
                     valid_q     <= 1'b0;
                     done_q      <= 1'b1;
                     max_exp_q   <= max_fold;
                     empty_cnt_q <= empty_fold;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign tile_valid = valid_q;
   assign tile_idx   = idx_q;
   assign tile_exp   = cur_exp;
   assign tile_bad   = cur_bad;
   assign score_snap = score_q;
   assign done       = done_q;
   assign max_exp    = max_exp_q;
   assign empty_cnt  = empty_cnt_q;

endmodule

// File: tb/tb_board_reader.sv
// Scoreboard bench for board_reader: expected records and frame statistics
// are queued when a frame starts and compared as the reader produces them.
module tb_board_reader;

   typedef struct packed {
      logic [3:0] idx;
      logic [4:0] e;
      logic       bad;
   } rec_t;

   typedef struct packed {
      logic [4:0]  mx;
      logic [4:0]  emp;
      logic [20:0] sc;
   } stat_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [319:0] board = '0;
   logic [20:0]  score = '0;
   logic         start = 1'b0;
   logic         tile_ready = 1'b0;
   logic         busy;
   logic         tile_valid;
   logic [3:0]   tile_idx;
   logic [4:0]   tile_exp;
   logic         tile_bad;
   logic [20:0]  score_snap;
   logic         done;
   logic [4:0]   max_exp;
   logic [4:0]   empty_cnt;

   rec_t  sb_q[$];
   stat_t st_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   always #5 clk = ~clk;

   board_reader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .board      (board),
      .score      (score),
      .start      (start),
      .busy       (busy),
      .tile_valid (tile_valid),
      .tile_ready (tile_ready),
      .tile_idx   (tile_idx),
      .tile_exp   (tile_exp),
      .tile_bad   (tile_bad),
      .score_snap (score_snap),
      .done       (done),
      .max_exp    (max_exp),
      .empty_cnt  (empty_cnt)
   );

   function automatic rec_t model(input int i, input logic [19:0] v);
      rec_t r;
      int unsigned vv;
      vv    = v;
      r.idx = i[3:0];
      r.e   = (vv == 0) ? 5'd0 : 5'($clog2(vv + 1) - 1);
      r.bad = (vv != 0) && ((vv == 1) || ($countones(v) != 1));
      return r;
   endfunction

   task automatic set_cell(input int i, input logic [19:0] v);
      board[i*20 +: 20] = v;
   endtask

   task automatic load_basic();
      board = '0;
      set_cell(0, 20'd2);
      set_cell(5, 20'd4);
      set_cell(15, 20'd2048);
      score = 21'd36;
   endtask

   task automatic load_extreme();
      board = '0;
      set_cell(3, 20'd6);
      set_cell(7, 20'd524288);
      set_cell(9, 20'd1);
      score = 21'($urandom);
   endtask

   task automatic push_frame();
      stat_t st;
      rec_t  r;
      st.mx  = '0;
      st.emp = '0;
      st.sc  = score;
      for (int i = 0; i < 16; i++) begin
         r = model(i, board[i*20 +: 20]);
         sb_q.push_back(r);
         if (r.e > st.mx) st.mx = r.e;
         if (board[i*20 +: 20] == 20'd0) st.emp = st.emp + 5'd1;
      end
      st_q.push_back(st);
   endtask

   // Called at a falling edge; returns at the falling edge after start is sampled.
   task automatic start_frame();
      push_frame();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic drain(input int ready_pct, input bit timing, input bit mid_start,
                        input bit start_in_done);
      int    cyc = 1;
      int    recs = 0;
      bit    got_done = 0;
      bit    stalled = 0;
      rec_t  held;
      rec_t  got;
      rec_t  want;
      stat_t st;
      held = '0;
      while (!got_done && cyc < 400) begin
         got = {tile_idx, tile_exp, tile_bad};
         if (stalled) begin
            n_cmp++;
            if (!tile_valid || got !== held) begin
               n_bad++;
               $display("FAIL stall_hold: got v=%b %h want v=1 %h", tile_valid, got, held);
            end
         end
         start = 1'b0;
         if (done) begin
            got_done = 1;
            if (st_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: got done=1 want no frame pending");
            end else begin
               st = st_q.pop_front();
               n_cmp++;
               if ({max_exp, empty_cnt, score_snap} !== {st.mx, st.emp, st.sc}) begin
                  n_bad++;
                  $display("FAIL frame_stats: got max=%0d empty=%0d score=%0d want %0d %0d %0d",
                           max_exp, empty_cnt, score_snap, st.mx, st.emp, st.sc);
               end
            end
            if (timing) begin
               n_cmp++;
               if (cyc != 17) begin
                  n_bad++;
                  $display("FAIL done_latency: got cycle %0d want 17", cyc);
               end
            end
            if (start_in_done) begin
               push_frame();
               start = 1'b1;
            end
         end
         stalled = 0;
         if (tile_valid) begin
            tile_ready = ($urandom_range(0, 99) < ready_pct);
            if (tile_ready) begin
               recs++;
               n_cmp++;
               if (sb_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL extra_record: got %h want none", got);
               end else begin
                  want = sb_q.pop_front();
                  if (got !== want) begin
                     n_bad++;
                     $display("FAIL record: got idx=%0d exp=%0d bad=%b want idx=%0d exp=%0d bad=%b",
                              got.idx, got.e, got.bad, want.idx, want.e, want.bad);
                  end
               end
            end else begin
               stalled = 1;
               held    = got;
            end
         end else begin
            tile_ready = ($urandom_range(0, 1) == 1);
         end
         if (mid_start && cyc == 5) begin
            board = ~board;
            score = ~score;
            start = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      n_cmp++;
      if (!got_done) begin
         n_bad++;
         $display("FAIL frame_timeout: got no done in %0d cycles want done", cyc);
      end
      n_cmp++;
      if (recs != 16) begin
         n_bad++;
         $display("FAIL record_count: got %0d want 16", recs);
      end
      if (timing && !start_in_done) begin
         n_cmp++;
         if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_after_done: got %b want 0", busy);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      n_cmp++;
      if ({busy, tile_valid, tile_idx, tile_exp, tile_bad, score_snap, done, max_exp,
           empty_cnt} !== 44'd0) begin
         n_bad++;
         $display("FAIL %s: got busy=%b v=%b idx=%h exp=%h bad=%b ss=%h done=%b max=%h emp=%h want all 0",
                  tag, busy, tile_valid, tile_idx, tile_exp, tile_bad, score_snap, done,
                  max_exp, empty_cnt);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         board      = {10{$urandom}};
         score      = 21'($urandom);
         start      = 1'($urandom);
         tile_ready = 1'($urandom);
         @(negedge clk);
         check_all_zero("reset_outputs");
      end
      start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (tile_valid !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got v=%b busy=%b want 0 0", tile_valid, busy);
         end
      end
   endtask

   task automatic test_basic();
      load_basic();
      start_frame();
      drain(100, 1, 0, 0);
      n_cmp++;
      if (max_exp !== 5'd11 || empty_cnt !== 5'd13 || score_snap !== 21'd36) begin
         n_bad++;
         $display("FAIL basic_stats: got %0d %0d %0d want 11 13 36", max_exp, empty_cnt, score_snap);
      end
   endtask

   task automatic test_backpressure();
      load_basic();
      start_frame();
      drain(50, 0, 0, 0);
   endtask

   task automatic test_extreme();
      load_extreme();
      start_frame();
      drain(100, 1, 0, 0);
      n_cmp++;
      if (max_exp !== 5'd19 || empty_cnt !== 5'd13) begin
         n_bad++;
         $display("FAIL extreme_stats: got %0d %0d want 19 13", max_exp, empty_cnt);
      end
   endtask

   task automatic test_snapshot();
      load_extreme();
      start_frame();
      drain(70, 0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (done !== 1'b0 || tile_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ignored_start: got done=%b v=%b want 0 0", done, tile_valid);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      load_basic();
      start_frame();
      // Board for the next frame; the running frame keeps its snapshot.
      load_extreme();
      drain(100, 1, 0, 1);
      n_cmp++;
      if (tile_valid !== 1'b1 || tile_idx !== 4'd0) begin
         n_bad++;
         $display("FAIL restart_in_done: got v=%b idx=%0d want 1 0", tile_valid, tile_idx);
      end
      drain(100, 1, 0, 0);
   endtask

   task automatic test_mid_reset();
      rec_t got;
      rec_t want;
      load_basic();
      start_frame();
      tile_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         got  = {tile_idx, tile_exp, tile_bad};
         want = sb_q.pop_front();
         n_cmp++;
         if (!tile_valid || got !== want) begin
            n_bad++;
            $display("FAIL pre_reset_record: got %h want %h", got, want);
         end
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_abort");
      sb_q.delete();
      st_q.delete();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_cmp++;
         if (done !== 1'b0 || tile_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_hold: got done=%b v=%b want 0 0", done, tile_valid);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      load_extreme();
      start_frame();
      drain(100, 1, 0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_extreme();
      test_snapshot();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
